// File: rtl/wb_write_arbiter.sv
// Write-back front end: owns the single register-file write port and merges
// in-order ALU results with buffered variable-latency load responses.
module wb_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [3:0]              alu_dest,
  input  logic [31:0]             alu_result,
  input  logic                    mem_rsp_valid,
  output logic                    mem_rsp_ready,
  input  logic [3:0]              mem_dest,
  input  logic [31:0]             mem_data,
  output logic                    writeBackEn,
  output logic [3:0]              Dest_wb,
  output logic [31:0]             Result_WB,
  output logic [14:0]             pending_mask,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    pc_wr_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_HI = SW'(STARVE_MAX);

  logic [3:0]    r_fifo_dest [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [SW-1:0] r_starve_cnt;
  logic          r_we;
  logic [3:0]    r_dest_wb;
  logic [31:0]   r_result_wb;
  logic          r_pc_drop;

  logic          w_nonempty;
  logic          w_alu_ready;
  logic          w_mem_ready;
  logic          w_alu_acc;
  logic          w_pop;
  logic          w_push;
  logic          w_grant;
  logic [3:0]    w_g_dest;
  logic [31:0]   w_g_data;
  logic [14:0]   w_pending;
  logic [15:0]   w_dec;

  assign w_nonempty  = (r_count != '0);
  assign w_mem_ready = (r_count != FULL_CNT);
  // Back-pressure the ALU once the queued loads have lost STARVE_MAX times in a row
  assign w_alu_ready = !(w_nonempty && (r_starve_cnt == STARVE_HI));
  assign w_alu_acc   = alu_valid && w_alu_ready;
  assign w_pop       = !w_alu_acc && w_nonempty;
  assign w_push      = mem_rsp_valid && w_mem_ready;
  assign w_grant     = w_alu_acc || w_pop;
  assign w_g_dest    = w_alu_acc ? alu_dest   : r_fifo_dest[r_rd_ptr];
  assign w_g_data    = w_alu_acc ? alu_result : r_fifo_data[r_rd_ptr];

  // Pending-destination mask over the live FIFO window; dest 15 never maps to a bit
  always_comb begin
    w_pending = 15'd0;
    w_dec     = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      w_dec     = 16'd1 << r_fifo_dest[i];
      w_pending = w_pending |
                  (({1'b0, AW'(AW'(i) - r_rd_ptr)} < r_count) ? w_dec[14:0] : 15'd0);
    end
  end

  // Load-response storage; contents are only meaningful inside the pointer window
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_dest[r_wr_ptr] <= mem_dest;
      r_fifo_data[r_wr_ptr] <= mem_data;
    end
  end

  // Pointers, occupancy, starvation counter and the registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
      r_we         <= 1'b0;
      r_dest_wb    <= 4'd0;
      r_result_wb  <= 32'd0;
      r_pc_drop    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_nonempty && w_alu_acc) begin
        r_starve_cnt <= (r_starve_cnt == STARVE_HI) ? r_starve_cnt : r_starve_cnt + SW'(1);
      end else begin
        r_starve_cnt <= '0;
      end
      // The PC is not in the register file: consume the entry but flag the drop
      r_we      <= w_grant && (w_g_dest != 4'd15);
      r_pc_drop <= w_grant && (w_g_dest == 4'd15);
      if (w_grant && (w_g_dest != 4'd15)) begin
        r_dest_wb   <= w_g_dest;
        r_result_wb <= w_g_data;
      end
    end
  end

  assign alu_ready     = w_alu_ready;
  assign mem_rsp_ready = w_mem_ready;
  assign writeBackEn   = r_we;
  assign Dest_wb       = r_dest_wb;
  assign Result_WB     = r_result_wb;
  assign pc_wr_drop    = r_pc_drop;
  assign pending_mask  = w_pending;
  assign fifo_count    = r_count;

endmodule
